sbox_layer_seq: RTL and testbench

- Sequential substitution layer for the Enc1 cipher datapath.
- Applies the 4-bit PRESENT S-box, forward or inverse, to every nibble of a WIDTH-bit state.
- Uses LANES S-box instances per cycle and iterates over the state in WIDTH/(4*LANES) cycles.
- Sits between the key-mix and permutation stages, with a valid/ready handshake on both sides.

---
 rtl/enc_pkg.sv | 25 ++
 rtl/sbox_lane.sv | 12 +
 rtl/sbox_layer_seq.sv | 106 ++++++++++
 tb/tb_sbox_layer_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the Enc1 substitution layer: FSM states and the
// 4-bit PRESENT S-box in both directions.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SBOX_FWD [0:15] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [0:15] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [3:0] sbox4(input logic [3:0] n, input logic inv);
        return inv ? SBOX_INV[n] : SBOX_FWD[n];
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane; direction chosen by inv.
module sbox_lane
    import enc_pkg::*;
(
    input  logic [3:0] x,
    input  logic       inv,
    output logic [3:0] r
);

    assign r = sbox4(x, inv);

endmodule

// File: rtl/sbox_layer_seq.sv
// Sequential S-box layer: substitutes LANES nibbles per cycle over WIDTH/(4*LANES)
// cycles, with valid/ready handshakes on input and output.
module sbox_layer_seq
    import enc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic             inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r
);

    localparam int STEPS = WIDTH / (4 * LANES);
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LW    = 4 * LANES;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if ((WIDTH % 4) != 0 || ((WIDTH / 4) % LANES) != 0) begin : g_param_chk
        $error("sbox_layer_seq: WIDTH must be a multiple of 4 and LANES must divide WIDTH/4");
    end

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  work, work_nxt;
    logic              mode;
    logic [LW-1:0]     lane_in, lane_out;
    int                base;

    always_comb begin
        base     = int'(cnt) * LW;
        lane_in  = work[base +: LW];
        work_nxt = work;
        work_nxt[base +: LW] = lane_out;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .x   (lane_in[i*4 +: 4]),
            .inv (mode),
            .r   (lane_out[i*4 +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // r is loaded once per operation so it holds still while work is rewritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            work <= '0;
            mode <= 1'b0;
            r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= x;
                        mode <= inv;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (cnt == LAST) begin
                        cnt <= '0;
                        r   <= work_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Randomized bench for sbox_layer_seq against a nibble-table reference model,
// plus latency checks on LANES=16 and LANES=1 builds.
module tb_sbox_layer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, inv, out_valid, out_ready;
    logic [63:0] x, r;
    logic        sv16, rdy16, ov16, sv1, rdy1, ov1;
    logic [63:0] r16, r1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sbox_layer_seq #(.WIDTH(64), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready), .r(r)
    );

    sbox_layer_seq #(.WIDTH(64), .LANES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sv16), .in_ready(rdy16), .x(x), .inv(inv),
        .out_valid(ov16), .out_ready(1'b1), .r(r16)
    );

    sbox_layer_seq #(.WIDTH(64), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(sv1), .in_ready(rdy1), .x(x), .inv(inv),
        .out_valid(ov1), .out_ready(1'b1), .r(r1)
    );

    bit [3:0] ft [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [3:0] sub(input logic [3:0] n, input logic iv);
        if (!iv) return ft[n];
        for (int j = 0; j < 16; j++)
            if (ft[j] == n) return 4'(j);
        return 4'h0;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] v, input logic iv);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[i*4 +: 4] = sub(v[i*4 +: 4], iv);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation on the default DUT; junk stimulus while busy/holding.
    task automatic do_op(input logic [63:0] xv, input logic iv, input int hold,
                         output logic [63:0] res);
        logic [63:0] exp;
        int lat;
        exp = model(xv, iv);
        @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; x = xv; inv = iv; out_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk("busy_ready", 64'(in_ready), 64'd0);
            x = {$urandom, $urandom}; inv = ~inv;
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("result", r, exp);
        chk("done_ready", 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; in_valid = 1'($urandom); x = {$urandom, $urandom};
            @(negedge clk);
            chk("hold_r", r, exp);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1; x = {$urandom, $urandom};
        @(negedge clk);
        chk("handoff_valid", 64'(out_valid), 64'd0);
        chk("handoff_no_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("r_retain", r, exp);
        res = r;
    endtask

    initial begin
        logic [63:0] res, res2, orig;
        int lat16, lat1;
        logic [63:0] c16, c1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inv = 1'b0; x = '0;
        sv16 = 1'b0; sv1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_r", r, 64'd0);
        rst = 1'b0;

        do_op(64'h0123456789ABCDEF, 1'b0, 0, res);
        chk("fwd_const", res, 64'hC56B90AD3EF84712);
        do_op(64'hC56B90AD3EF84712, 1'b1, 1, res);
        chk("inv_const", res, 64'h0123456789ABCDEF);
        do_op(64'hCCCCCCCCCCCCCCCC, 1'b1, 0, res);
        chk("inv_to_zero", res, 64'd0);
        do_op(64'd0, 1'b0, 6, res);
        chk("backpressure", res, 64'hCCCCCCCCCCCCCCCC);

        for (int k = 0; k < 6; k++) begin
            orig = {$urandom, $urandom};
            do_op(orig, 1'b0, int'($urandom_range(0, 2)), res);
            do_op(res, 1'b1, 0, res2);
            chk("roundtrip", res2, orig);
        end
        for (int k = 0; k < 12; k++)
            do_op({$urandom, $urandom}, 1'($urandom), int'($urandom_range(0, 3)), res);

        // Asynchronous reset two cycles into BUSY.
        @(negedge clk);
        in_valid = 1'b1; x = 64'hFFFF0000FFFF0000; inv = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_r", r, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(64'h1111111111111111, 1'b0, 0, res);
        chk("post_rst", res, 64'h5555555555555555);

        // Lane-count sweep.
        @(negedge clk);
        x = 64'h0123456789ABCDEF; inv = 1'b0; sv16 = 1'b1; sv1 = 1'b1;
        @(negedge clk);
        sv16 = 1'b0; sv1 = 1'b0;
        lat16 = -1; lat1 = -1; c16 = '0; c1 = '0;
        for (int c = 0; c < 40; c++) begin
            if (lat16 < 0 && ov16) begin lat16 = c; c16 = r16; end
            if (lat1 < 0 && ov1) begin lat1 = c; c1 = r1; end
            @(negedge clk);
        end
        chk("lat_l16", 64'(lat16), 64'd1);
        chk("res_l16", c16, 64'hC56B90AD3EF84712);
        chk("lat_l1", 64'(lat1), 64'd16);
        chk("res_l1", c1, 64'hC56B90AD3EF84712);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
